// File: rtl/icache_fill_ctrl_pkg.sv
// Shared definitions for the instruction cache fill controller: line geometry,
// address width and the fill sequencer state encoding.
package icache_fill_ctrl_pkg;

  localparam int ICACHE_LINE_SIZ = 16;
  localparam int ICACHE_LINE_WID = ICACHE_LINE_SIZ * 8;
  localparam int ADDR_WID        = 32;

  typedef enum logic [1:0] {
    ICF_IDLE  = 2'd0,
    ICF_FILL  = 2'd1,
    ICF_DRAIN = 2'd2
  } icf_state_e;

endpackage

// File: rtl/icache_store.sv
// Direct-mapped line storage: data/tag/valid arrays with an asynchronous read
// port, a single write port and an asynchronous clear of the valid bits.
module icache_store
  import icache_fill_ctrl_pkg::*;
#(
  parameter int LINE_W    = ICACHE_LINE_WID,
  parameter int NUM_LINES = 16,
  parameter int IDX_W     = 4,
  parameter int TAG_W     = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [LINE_W-1:0] rd_line,
  input  logic              we,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [LINE_W-1:0] wr_line
);

  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [LINE_W-1:0]    data_q [NUM_LINES];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (we) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // Tags and data are don't-care until their valid bit is set, so no reset.
  always_ff @(posedge clk) begin
    if (we) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_line;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_line  = data_q[rd_idx];

endmodule

// File: rtl/icache_fill_ctrl.sv
// Direct-mapped instruction cache with a whole-line fill sequencer that is the
// sole driver of the memory controller's instruction-fetch port.
module icache_fill_ctrl
  import icache_fill_ctrl_pkg::*;
#(
  parameter int LINE_BYTES = ICACHE_LINE_SIZ,
  parameter int NUM_LINES  = 16,
  parameter int ADDR_W     = ADDR_WID
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    rollback,
  input  logic                    fe_req,
  input  logic [ADDR_W-1:0]       fe_pc,
  output logic                    fe_ready,
  output logic [31:0]             fe_inst,
  output logic                    mc_if_en,
  output logic [ADDR_W-1:0]       mc_if_pc,
  input  logic                    mc_if_done,
  input  logic [LINE_BYTES*8-1:0] mc_if_data,
  output icf_state_e              dbg_state
);

  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
  localparam int LINE_W = LINE_BYTES * 8;
  localparam int WORDS  = LINE_BYTES / 4;

  // Handshake: mc_if_en rises with a line-aligned mc_if_pc and both hold
  // until a one-cycle mc_if_done; a DRAIN cycle with mc_if_en low follows so
  // the controller sees the request drop before any new one.
  icf_state_e        state_q, state_d;
  logic              en_q, en_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [IDX_W-1:0]  miss_idx_q, miss_idx_d;
  logic [TAG_W-1:0]  miss_tag_q, miss_tag_d;
  logic              we;

  logic [OFF_W-1:0]  off;
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic              rd_valid;
  logic [TAG_W-1:0]  rd_tag;
  logic [LINE_W-1:0] rd_line;
  logic              hit;

  assign off = fe_pc[OFF_W-1:0];
  assign idx = fe_pc[OFF_W+IDX_W-1:OFF_W];
  assign tag = fe_pc[ADDR_W-1:OFF_W+IDX_W];

  icache_store #(
    .LINE_W    (LINE_W),
    .NUM_LINES (NUM_LINES),
    .IDX_W     (IDX_W),
    .TAG_W     (TAG_W)
  ) u_store (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (idx),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_line  (rd_line),
    .we       (we),
    .wr_idx   (miss_idx_q),
    .wr_tag   (miss_tag_q),
    .wr_line  (mc_if_data)
  );

  assign hit      = rd_valid && (rd_tag == tag);
  assign fe_ready = rdy && fe_req && (state_q == ICF_IDLE) && hit;

  always_comb begin
    fe_inst = '0;
    for (int i = 0; i < WORDS; i++) begin
      if ((off >> 2) == OFF_W'(i)) fe_inst = rd_line[32*i +: 32];
    end
  end

  always_comb begin
    state_d    = state_q;
    en_d       = en_q;
    pc_d       = pc_q;
    miss_idx_d = miss_idx_q;
    miss_tag_d = miss_tag_q;
    we         = 1'b0;
    if (rdy) begin
      case (state_q)
        ICF_IDLE: begin
          if (fe_req && !hit && !rollback) begin
            en_d       = 1'b1;
            pc_d       = {fe_pc[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            miss_idx_d = idx;
            miss_tag_d = tag;
            state_d    = ICF_FILL;
          end
        end
        // Rollback does not abort: the controller finishes the fill anyway.
        ICF_FILL: begin
          if (mc_if_done) begin
            we      = 1'b1;
            en_d    = 1'b0;
            state_d = ICF_DRAIN;
          end
        end
        ICF_DRAIN: state_d = ICF_IDLE;
        default:   state_d = ICF_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ICF_IDLE;
      en_q       <= 1'b0;
      pc_q       <= '0;
      miss_idx_q <= '0;
      miss_tag_q <= '0;
    end else begin
      state_q    <= state_d;
      en_q       <= en_d;
      pc_q       <= pc_d;
      miss_idx_q <= miss_idx_d;
      miss_tag_q <= miss_tag_d;
    end
  end

  assign mc_if_en  = en_q;
  assign mc_if_pc  = pc_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Directed and randomized fetch sequences against a line-level cache model and
// a behavioural memory controller that returns byte i = line address low byte + i.
module tb_icache_fill_ctrl;
  import icache_fill_ctrl_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         rdy = 1'b1;
  logic         rollback = 1'b0;
  logic         fe_req = 1'b0;
  logic [31:0]  fe_pc = '0;
  logic         fe_ready;
  logic [31:0]  fe_inst;
  logic         mc_if_en;
  logic [31:0]  mc_if_pc;
  logic         mc_if_done = 1'b0;
  logic [127:0] mc_if_data = '0;
  icf_state_e   dbg_state;

  int checks = 0;
  int errors = 0;

  bit          m_valid [16];
  logic [23:0] m_tag   [16];

  always #5 clk = ~clk;

  icache_fill_ctrl #(.LINE_BYTES(16), .NUM_LINES(16), .ADDR_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .rollback   (rollback),
    .fe_req     (fe_req),
    .fe_pc      (fe_pc),
    .fe_ready   (fe_ready),
    .fe_inst    (fe_inst),
    .mc_if_en   (mc_if_en),
    .mc_if_pc   (mc_if_pc),
    .mc_if_done (mc_if_done),
    .mc_if_data (mc_if_data),
    .dbg_state  (dbg_state)
  );

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  function automatic logic [127:0] line_of(input logic [31:0] base);
    logic [127:0] d;
    for (int b = 0; b < 16; b++) d[8*b +: 8] = base[7:0] + 8'(b);
    return d;
  endfunction

  function automatic logic [31:0] exp_inst(input logic [31:0] pc);
    logic [7:0] lb;
    lb = {pc[7:4], 4'h0} + {4'h0, pc[3:2], 2'b00};
    return {lb + 8'd3, lb + 8'd2, lb + 8'd1, lb};
  endfunction

  function automatic bit model_hit(input logic [31:0] pc);
    return m_valid[pc[7:4]] && (m_tag[pc[7:4]] == pc[31:8]);
  endfunction

  // One fetch: a hit answers in the same cycle; a miss runs a fill with an
  // optional accept delay, rollback during FILL and a 3-cycle rdy drop.
  task automatic fetch(input logic [31:0] pc, input int stall, input bit rb, input bit rdy_drop);
    logic [31:0] base;
    bit          exp_hit;
    base    = {pc[31:4], 4'h0};
    exp_hit = model_hit(pc);
    @(negedge clk); fe_req = 1'b1; fe_pc = pc; #1;
    chk("lookup_ready", 32'(fe_ready), 32'(exp_hit));
    if (exp_hit) begin
      chk("hit_inst", fe_inst, exp_inst(pc));
      chk("hit_no_fill", 32'(mc_if_en), 32'd0);
      fe_req = 1'b0;
      return;
    end
    @(negedge clk); fe_pc = $urandom; rollback = rb; #1;
    chk("fill_en", 32'(mc_if_en), 32'd1);
    chk("fill_pc", mc_if_pc, base);
    chk("fill_ready", 32'(fe_ready), 32'd0);
    for (int k = 0; k < stall; k++) begin
      @(negedge clk); #1;
      chk("stall_en", 32'(mc_if_en), 32'd1);
      chk("stall_pc", mc_if_pc, base);
      chk("stall_ready", 32'(fe_ready), 32'd0);
    end
    if (rdy_drop) begin
      for (int k = 0; k < 3; k++) begin
        @(negedge clk); rdy = 1'b0; mc_if_done = (k == 0); mc_if_data = '1; fe_pc = pc; #1;
        chk("nordy_en", 32'(mc_if_en), 32'd1);
        chk("nordy_pc", mc_if_pc, base);
        chk("nordy_ready", 32'(fe_ready), 32'd0);
      end
      @(negedge clk); rdy = 1'b1; mc_if_done = 1'b0; #1;
      chk("rdy_back_en", 32'(mc_if_en), 32'd1);
      chk("rdy_back_ready", 32'(fe_ready), 32'd0);
    end
    @(negedge clk); mc_if_done = 1'b1; mc_if_data = line_of(base); #1;
    chk("done_cycle_en", 32'(mc_if_en), 32'd1);
    @(negedge clk); mc_if_done = 1'b0; rollback = 1'b0; fe_pc = pc; #1;
    m_valid[pc[7:4]] = 1'b1;
    m_tag[pc[7:4]]   = pc[31:8];
    chk("drain_en", 32'(mc_if_en), 32'd0);
    chk("drain_ready", 32'(fe_ready), 32'd0);
    @(negedge clk); #1;
    chk("refetch_ready", 32'(fe_ready), 32'd1);
    chk("refetch_inst", fe_inst, exp_inst(pc));
    chk("refetch_en", 32'(mc_if_en), 32'd0);
    fe_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) begin m_valid[i] = 1'b0; m_tag[i] = '0; end

    // Reset state, with a request pending
    fe_req = 1'b1; fe_pc = 32'h0000_1004;
    #2;
    chk("reset_en", 32'(mc_if_en), 32'd0);
    chk("reset_pc", mc_if_pc, 32'd0);
    chk("reset_ready", 32'(fe_ready), 32'd0);
    repeat (2) @(negedge clk);
    fe_req = 1'b0; rst = 1'b1;

    // Cold miss, same-line hit, conflict
    fetch(32'h0000_1004, 2, 1'b0, 1'b0);
    chk("cold_inst_const", fe_inst, 32'h0706_0504);
    fetch(32'h0000_100C, 0, 1'b0, 1'b0);
    chk("same_line_const", fe_inst, 32'h0F0E_0D0C);
    fetch(32'h0000_1104, 1, 1'b0, 1'b0);
    fetch(32'h0000_1004, 0, 1'b0, 1'b0);

    // A hit is masked while rdy is low
    @(negedge clk); fe_req = 1'b1; fe_pc = 32'h0000_1008; rdy = 1'b0; #1;
    chk("nordy_hit_ready", 32'(fe_ready), 32'd0);
    rdy = 1'b1; #1;
    chk("rdy_hit_ready", 32'(fe_ready), 32'd1);
    chk("rdy_hit_inst", fe_inst, 32'h0B0A_0908);
    fe_req = 1'b0;

    // Delayed accept with rollback during FILL, then a hit in that line
    fetch(32'h0000_2020, 10, 1'b1, 1'b0);
    fetch(32'h0000_202C, 0, 1'b0, 1'b0);

    // rdy dropped mid-FILL, including a done pulse that must be ignored
    fetch(32'h0000_3050, 1, 1'b0, 1'b1);

    // Rollback in IDLE suppresses the miss
    @(negedge clk); fe_req = 1'b1; fe_pc = 32'h0000_5070; rollback = 1'b1; #1;
    chk("rb_idle_ready", 32'(fe_ready), 32'd0);
    @(negedge clk); rollback = 1'b0; fe_req = 1'b0; #1;
    chk("rb_idle_no_fill", 32'(mc_if_en), 32'd0);

    // Stray done while IDLE must not corrupt a resident line
    @(negedge clk); mc_if_done = 1'b1; mc_if_data = '1;
    @(negedge clk); mc_if_done = 1'b0;
    fetch(32'h0000_1004, 0, 1'b0, 1'b0);

    // Randomized fetches over a small tag pool to mix hits and conflicts
    for (int n = 0; n < 40; n++) begin
      logic [31:0] pc;
      pc = (32'($urandom_range(16'h0010, 16'h0013)) << 8) | (32'($urandom_range(0, 15)) << 4)
         | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      fetch(pc, $urandom_range(0, 4), ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
    end

    // Asynchronous reset between edges during a fill
    @(negedge clk); fe_req = 1'b1; fe_pc = 32'h0000_6000 | {24'h0, m_tag[0] == 24'h000066 ? 8'h10 : 8'h00};
    fe_pc = model_hit(fe_pc) ? 32'h0000_7700 : fe_pc;
    @(negedge clk); #1;
    chk("pre_reset_en", 32'(mc_if_en), 32'd1);
    #1 rst = 1'b0; #1;
    chk("async_reset_en", 32'(mc_if_en), 32'd0);
    chk("async_reset_pc", mc_if_pc, 32'd0);
    chk("async_reset_ready", 32'(fe_ready), 32'd0);
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    @(negedge clk); rst = 1'b1; fe_req = 1'b0;
    chk("post_reset_model_miss", 32'(model_hit(32'h0000_1004)), 32'd0);
    fetch(32'h0000_1004, 0, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
